hilo_unit: RTL and testbench
============================

Name: hilo_unit

Overview:
- Sequential front/back end wrapped around the existing unsigned 32x32->64 MULT array.
- Upstream side: accepts MULT/MULTU/MTHI/MTLO issue from the CPU execute stage and drives magnitude operands into MULT, holding them stable for the full latency.
- Downstream side: captures MULT's 64-bit product, applies the sign fix-up, and commits the result to the HI/LO registers.
- Serves MFHI/MFLO reads and generates the pipeline stall while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width; the product and HI:LO pair are 2*WIDTH.
- MUL_LATENCY, 4, cycles from mul_a/mul_b becoming valid to z being valid on mul_prod; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; low clears all state.
- start  in  1  issue strobe, one cycle per operation.
- op  in  3  000 MULT, 001 MULTU, 010 MTHI, 011 MTLO, 100 MADD, 101 MADDU; others no-op.
- rs_val  in  WIDTH  operand A, or the write data for MTHI/MTLO.
- rt_val  in  WIDTH  operand B.
- rd_hi  in  1  MFHI request.
- rd_lo  in  1  MFLO request.
- mul_a  out  WIDTH  registered magnitude of A, driven to MULT.
- mul_b  out  WIDTH  registered magnitude of B, driven to MULT.
- mul_prod  in  2*WIDTH  MULT output z.
- rd_data  out  WIDTH  HI or LO value.
- busy  out  1  a multiply is in flight.
- stall  out  1  the upstream stage must hold its instruction.

Behaviour:
- Reset values: HI=0, LO=0, mul_a=0, mul_b=0, busy=0, stall=0, rd_data=0, cnt=0, state=IDLE.
- State machine:
  - IDLE:
    - start with MULT/MULTU: latch mul_a/mul_b, set neg, go to RUN. Signed ops latch mul_a=|rs_val| and mul_b=|rt_val|, neg=rs_val[MSB]^rt_val[MSB]. Unsigned ops pass operands raw, neg=0.
    - start with MTHI/MTLO: write HI or LO at this edge; stay in IDLE.
  - RUN:
    - busy=1; cnt increments from 0.
    - When cnt==MUL_LATENCY-1, sample mul_prod next edge and go to COMMIT.
  - COMMIT:
    - res = neg ? (~mul_prod + 1) : mul_prod, 2*WIDTH two's complement.
    - HI<=res[2W-1:W], LO<=res[W-1:0]; busy<=0; back to IDLE.
- Latency: HI/LO are updated MUL_LATENCY+1 edges after the issue edge.
- mul_a and mul_b hold stable throughout RUN and COMMIT.
- Magnitude of 0x80000000 is 0x80000000, interpreted as unsigned; this is exact.
- rd_data:
  - Combinational: rd_hi selects HI, else rd_lo selects LO, else 0.
  - rd_hi has priority if both are asserted.
- stall is combinational, asserted when busy and any of: start, rd_hi, rd_lo.
  - A start issued while busy is ignored; upstream holds it until stall drops.
  - No read bypass from the in-flight result; HI/LO are read only after COMMIT.
- Same-edge MTHI at COMMIT cannot occur, because stall blocks it.
- Reset asserted mid-operation: result discarded, HI/LO cleared, state=IDLE, asynchronously.
- Undefined op with start: no state change, no stall.

Optional Feature:
- Macro: HILO_MADD_EN.
- Defined:
  - op 100/101 (MADD/MADDU) run like MULT/MULTU.
  - At COMMIT, {HI,LO} <= {HI,LO} + res, using the HI/LO value at COMMIT, modulo 2^(2W).
- Undefined:
  - op 100/101 are treated as undefined no-ops.

Decomposition:
- Shared package hilo_pkg holds:
  - Op encoding constants: OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO, OP_MADD, OP_MADDU.
  - FSM state enum: IDLE, RUN, COMMIT.
  - Default WIDTH.
- Sub-module hilo_signfix: combinational abs-in/negate-out helper. It holds the |x| function and the conditional two's-complement of the 64-bit product.
- The counter and FSM stay in hilo_unit.

Test Plan:
- Reset low mid-RUN after MULT 5*6 → busy=0, HI=LO=0 immediately; no commit afterward.
- MULT rs=0xFFFFFFFD (-3), rt=7 → after MUL_LATENCY+1 edges: HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly MUL_LATENCY+1 cycles.
- MULTU rs=rt=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. The same operands with MULT → HI=0, LO=1.
- MULT rs=0x80000000, rt=2 → HI=0xFFFFFFFF, LO=0; mul_a=0x80000000 held stable all through RUN.
- MULT then rd_lo asserted the following cycle → stall=1 until COMMIT; rd_data=new LO on the first unstalled cycle. MTHI 0x1234 issued while busy → stall, and HI unchanged until reissued.
- With HILO_MADD_EN: MTLO 10, then MADDU 3*4 → LO=22, HI=0. Without the macro: same sequence leaves LO=10.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO multiply unit: op encodings, FSM states,
// default operand width and the op-decode helper.
// HILO_MADD_EN: when defined, MADD/MADDU accumulate into {HI,LO}.
package hilo_pkg;

    localparam int unsigned DEF_WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    // True for every op that launches a multiply in this build.
    function automatic logic is_mul_op(input logic [2:0] op);
        case (op)
            OP_MULT, OP_MULTU: return 1'b1;
`ifdef HILO_MADD_EN
            OP_MADD, OP_MADDU: return 1'b1;
`endif
            default:           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/hilo_signfix.sv
// Combinational sign handling around the unsigned MULT array: operand
// magnitudes on the way in, conditional negation of the product on the way out.
module hilo_signfix
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   prod,
    input  logic                 neg,
    output logic [WIDTH-1:0]     a_mag,
    output logic [WIDTH-1:0]     b_mag,
    output logic                 prod_neg,
    output logic [2*WIDTH-1:0]   res
);

    // |x| for signed ops (most-negative value maps to itself, read unsigned),
    // raw pass-through otherwise; product sign from the operand MSBs.
    always_comb begin
        a_mag    = (is_signed && a[WIDTH-1]) ? (~a + (WIDTH)'(1)) : a;
        b_mag    = (is_signed && b[WIDTH-1]) ? (~b + (WIDTH)'(1)) : b;
        prod_neg = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        res      = neg ? (~prod + (2*WIDTH)'(1)) : prod;
    end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: issues operand magnitudes to the external MULT array,
// waits MUL_LATENCY cycles, sign-fixes the product and commits it to HI/LO.
// Serves MFHI/MFLO reads and stalls upstream while a multiply is in flight.
// HILO_MADD_EN: when defined, MADD/MADDU add the product into {HI,LO}.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned WIDTH       = DEF_WIDTH,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     rs_val,
    input  logic [WIDTH-1:0]     rt_val,
    input  logic                 rd_hi,
    input  logic                 rd_lo,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_prod,
    output logic [WIDTH-1:0]     rd_data,
    output logic                 busy,
    output logic                 stall
);

    localparam logic [3:0] LAST = 4'(MUL_LATENCY - 1);

    state_t               state, state_next;
    logic [3:0]           cnt;
    logic                 neg;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     hi, lo;
    logic [WIDTH-1:0]     a_mag, b_mag;
    logic                 prod_neg;
    logic [2*WIDTH-1:0]   res;
    logic [2*WIDTH-1:0]   commit_val;
    logic                 issue;
`ifdef HILO_MADD_EN
    logic                 acc;
`endif

    assign issue = start && is_mul_op(op);

    hilo_signfix #(.WIDTH(WIDTH)) u_signfix (
        .is_signed (~op[0]),
        .a         (rs_val),
        .b         (rt_val),
        .prod      (prod_q),
        .neg       (neg),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .prod_neg  (prod_neg),
        .res       (res)
    );

`ifdef HILO_MADD_EN
    assign commit_val = acc ? ({hi, lo} + res) : res;
`else
    assign commit_val = res;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state: IDLE -> RUN on a multiply issue, RUN for MUL_LATENCY cycles,
    // one COMMIT cycle, then back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue) state_next = RUN;
            RUN:     if (cnt == LAST) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, latency counter, product capture, HI/LO writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            mul_a  <= '0;
            mul_b  <= '0;
            neg    <= 1'b0;
            prod_q <= '0;
            cnt    <= '0;
`ifdef HILO_MADD_EN
            acc    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        mul_a <= a_mag;
                        mul_b <= b_mag;
                        neg   <= prod_neg;
                        cnt   <= '0;
`ifdef HILO_MADD_EN
                        acc   <= op[2];
`endif
                    end else if (start && op == OP_MTHI) begin
                        hi <= rs_val;
                    end else if (start && op == OP_MTLO) begin
                        lo <= rs_val;
                    end
                end
                RUN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) prod_q <= mul_prod;
                end
                COMMIT: {hi, lo} <= commit_val;
                default: ;
            endcase
        end
    end

    // Read mux (HI wins) and upstream stall.
    always_comb begin
        busy = (state != IDLE);
        if (rd_hi)      rd_data = hi;
        else if (rd_lo) rd_data = lo;
        else            rd_data = '0;
        stall = busy && (start || rd_hi || rd_lo);
    end

endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;

    localparam int L = 4;

    localparam logic [2:0] T_MULT  = 3'b000;
    localparam logic [2:0] T_MULTU = 3'b001;
    localparam logic [2:0] T_MTHI  = 3'b010;
    localparam logic [2:0] T_MTLO  = 3'b011;
    localparam logic [2:0] T_MADDU = 3'b101;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] rs_val = '0, rt_val = '0;
    logic        rd_hi = 1'b0, rd_lo = 1'b0;
    logic [31:0] mul_a, mul_b, rd_data;
    logic [63:0] mul_prod;
    logic        busy, stall;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = '0, m_lo = '0;

    // Behavioural MULT array: product of the operands as they were L-1 edges ago.
    logic [63:0] hist [0:14];

    always #5 clk = ~clk;

    initial for (int i = 0; i < 15; i++) hist[i] = '0;

    always @(posedge clk) begin
        hist[0] <= {32'b0, mul_a} * {32'b0, mul_b};
        for (int i = 1; i < 15; i++) hist[i] <= hist[i-1];
    end

    assign mul_prod = hist[L-2];

    hilo_unit #(.WIDTH(32), .MUL_LATENCY(L)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .rd_hi    (rd_hi),
        .rd_lo    (rd_lo),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_prod (mul_prod),
        .rd_data  (rd_data),
        .busy     (busy),
        .stall    (stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_is_mul(input logic [2:0] o);
`ifdef HILO_MADD_EN
        return (o == 3'b000) || (o == 3'b001) || (o == 3'b100) || (o == 3'b101);
`else
        return (o == 3'b000) || (o == 3'b001);
`endif
    endfunction

    // Mathematical product: signed ops as true signed integers, modulo 2^64.
    function automatic logic [63:0] model_prod(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        if (!o[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        ua = 64'(a);
        ub = 64'(b);
        return ua * ub;
    endfunction

    // Call right after a negedge: checks HI, LO (with HI priority) and idle read.
    task automatic read_check(input string tag);
        rd_hi = 1'b1; rd_lo = 1'($urandom_range(0, 1));
        #1 chk({tag, "_hi"}, 64'(rd_data), 64'(m_hi));
        rd_hi = 1'b0; rd_lo = 1'b1;
        #1 chk({tag, "_lo"}, 64'(rd_data), 64'(m_lo));
        rd_lo = 1'b0;
        #1 chk({tag, "_none"}, 64'(rd_data), 64'd0);
    endtask

    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ea, eb;
        logic [63:0] r;
        int n;
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        #1 chk("issue_no_stall", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        if (model_is_mul(o)) begin
            ea = (!o[0] && a[31]) ? (32'd0 - a) : a;
            eb = (!o[0] && b[31]) ? (32'd0 - b) : b;
            r  = model_prod(o, a, b);
            if (o[2]) {m_hi, m_lo} = {m_hi, m_lo} + r;
            else      {m_hi, m_lo} = r;
            n = 0;
            while (busy === 1'b1 && n < 40) begin
                n++;
                chk("mul_a_hold", 64'(mul_a), 64'(ea));
                chk("mul_b_hold", 64'(mul_b), 64'(eb));
                @(negedge clk);
            end
            chk("busy_cycles", 64'(n), 64'(L + 1));
        end else begin
            if (o == T_MTHI) m_hi = a;
            if (o == T_MTLO) m_lo = a;
            chk("nonmul_busy", 64'(busy), 64'd0);
        end
        read_check("hilo");
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        logic [2:0]  o;

        // Reset state
        repeat (2) @(negedge clk);
        #1 chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_mul_a", 64'(mul_a), 64'd0);
        chk("rst_mul_b", 64'(mul_b), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        read_check("rst");

        // Directed products
        do_op(T_MULT,  32'hFFFF_FFFD, 32'd7);
        do_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(T_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(T_MULT,  32'h8000_0000, 32'd2);
        do_op(T_MULT,  32'h8000_0000, 32'h8000_0000);
        do_op(T_MULTU, 32'h8000_0000, 32'd3);

        // MFLO while busy: stall until commit, then the new LO appears
        @(negedge clk);
        start = 1'b1; op = T_MULT; rs_val = 32'h0001_2345; rt_val = 32'hFFFF_FF00;
        {m_hi, m_lo} = model_prod(T_MULT, 32'h0001_2345, 32'hFFFF_FF00);
        @(negedge clk);
        start = 1'b0; rd_lo = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            #1 chk("stall_rd_lo", 64'(stall), 64'd1);
            n++;
            @(negedge clk);
        end
        chk("stall_rd_cycles", 64'(n), 64'(L + 1));
        #1 chk("unstall_rd_lo", 64'(stall), 64'd0);
        chk("unstall_lo_data", 64'(rd_data), 64'(m_lo));
        rd_lo = 1'b0;

        // MTHI while busy is held off and ignored
        @(negedge clk);
        start = 1'b1; op = T_MULTU; rs_val = 32'd1000; rt_val = 32'd3000;
        {m_hi, m_lo} = model_prod(T_MULTU, 32'd1000, 32'd3000);
        @(negedge clk);
        op = T_MTHI; rs_val = 32'h0000_1234;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            #1 chk("stall_mthi", 64'(stall), 64'd1);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("stall_mthi_cycles", 64'(n), 64'(L + 1));
        read_check("mthi_ignored");
        do_op(T_MTHI, 32'h0000_1234, 32'd0);

        // Undefined ops change nothing
        do_op(3'b110, 32'hDEAD_BEEF, 32'd5);
        do_op(3'b111, 32'hCAFE_F00D, 32'd9);

        // MADDU accumulate (no-op without the accumulate build)
        do_op(T_MTHI, 32'd0, 32'd0);
        do_op(T_MTLO, 32'd10, 32'd0);
        do_op(T_MADDU, 32'd3, 32'd4);
        do_op(3'b100, 32'hFFFF_FFFE, 32'd5);

        // Randomized mix
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'd0;
                default: a = $urandom;
            endcase
            b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            do_op(o, a, b);
        end

        // Reset in the middle of a multiply: cleared at once, no late commit
        do_op(T_MTHI, 32'h0000_AAAA, 32'd0);
        do_op(T_MTLO, 32'h0000_5555, 32'd0);
        @(negedge clk);
        start = 1'b1; op = T_MULT; rs_val = 32'd5; rt_val = 32'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1 chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_mul_a", 64'(mul_a), 64'd0);
        rd_hi = 1'b1;
        #1 chk("midrst_hi", 64'(rd_data), 64'd0);
        rd_hi = 1'b0; rd_lo = 1'b1;
        #0.5 chk("midrst_lo", 64'(rd_data), 64'd0);
        rd_lo = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (L + 3) begin
            @(negedge clk);
            chk("postrst_busy", 64'(busy), 64'd0);
        end
        read_check("postrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
